// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family: FSM state encoding and
// the bit-counter sizing helper.
package shift_reg_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } tx_state_t;

    // Bits needed to count 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and
// streams it one bit per clock, optionally followed by an even-parity bit.
module shift_reg_piso_tx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PENULT   = CW'(WIDTH - 2);

    tx_state_t        state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt_reg;
    logic             parity_reg;
    logic             sout_reg;
    logic             sout_valid_reg;
    logic             done_reg;

    logic [WIDTH-1:0] d_ordered;
    logic             last_bit;
    logic             accept;

    // Reorder the word so the first bit on the wire is always bit 0; the
    // shift register then only ever shifts right.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign d_ordered[gi] = d[WIDTH-1-gi];
            end else begin : g_lsb
                assign d_ordered[gi] = d[gi];
            end
        end
    endgenerate

    always_comb begin
        last_bit = 1'b0;
        if (state_reg == PARITY) begin
            last_bit = 1'b1;
        end else if (state_reg == SHIFT && cnt_reg == LAST_IDX && PARITY_EN == 0) begin
            last_bit = 1'b1;
        end
    end

    assign d_ready = !reset && (state_reg == IDLE || last_bit);
    assign accept  = d_valid && d_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            parity_reg     <= 1'b0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else if (accept) begin
            // First bit goes out at the accepting edge; WIDTH >= 2 so it
            // can never also be the last bit.
            state_reg      <= SHIFT;
            shift_reg      <= d_ordered;
            cnt_reg        <= '0;
            parity_reg     <= ^d;
            sout_reg       <= d_ordered[0];
            sout_valid_reg <= 1'b1;
            done_reg       <= 1'b0;
        end else if (last_bit) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else if (state_reg == SHIFT) begin
            if (cnt_reg == LAST_IDX) begin
                // Only reachable with parity enabled: append the parity bit.
                state_reg <= PARITY;
                cnt_reg   <= '0;
                sout_reg  <= parity_reg;
                done_reg  <= 1'b1;
            end else begin
                shift_reg <= shift_reg >> 1;
                cnt_reg   <= cnt_reg + 1'b1;
                sout_reg  <= shift_reg[1];
                done_reg  <= (PARITY_EN == 0) && (cnt_reg == PENULT);
            end
        end
    end

    assign sout       = sout_reg;
    assign sout_valid = sout_valid_reg;
    assign done       = done_reg;
    assign busy       = sout_valid_reg;

endmodule
